// File: rtl/lfsr_param_if.sv
// Burst command handshake between a controller (master) and the LFSR (slave):
// request/step count in, ready/busy/done status out.
interface lfsr_param_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_ready;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_steps,
    input  cmd_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_steps,
    output cmd_ready, busy, done
  );
endinterface

// File: rtl/lfsr_param.sv
// Parametrised Galois LFSR with free-run enable, seed load, counted bursts and zero-lock fix.
// Optional period checker (period_wrap/period_cnt) enabled by defining LFSR_PERIOD_CHK_EN.
module lfsr_param #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1C),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  lfsr_param_if.slave      cmd,
  output logic             zero_fix,
`ifdef LFSR_PERIOD_CHK_EN
  output logic             period_wrap,
  output logic [WIDTH-1:0] period_cnt,
`endif
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             done_q, done_nxt;
  logic             zfix_q, zfix_nxt;
  logic             step_fire;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_val;

  // One Galois shift: MSB feeds bit 0 and is XORed into every tapped position.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r[0] = v[WIDTH-1];
    for (int i = 1; i < WIDTH; i++) begin
      r[i] = v[i-1] ^ (TAPS[i] & v[WIDTH-1]);
    end
    return r;
  endfunction

  assign q_step   = lfsr_step(q);
  assign load_val = (data_in == '0) ? SEED : data_in;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    q_nxt         = q;
    done_nxt      = 1'b0;
    zfix_nxt      = 1'b0;
    step_fire     = 1'b0;
    cmd.cmd_ready = (state == IDLE) && !load;
    cmd.busy      = (state == BURST);

    if (load) begin
      // Load wins over everything and silently aborts a running burst.
      q_nxt     = load_val;
      zfix_nxt  = (data_in == '0);
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            if (cmd.cmd_steps == '0) begin
              done_nxt = 1'b1;
            end else begin
              cnt_nxt   = cmd.cmd_steps;
              state_nxt = BURST;
            end
          end else if (en) begin
            q_nxt     = q_step;
            step_fire = 1'b1;
          end
        end
        BURST: begin
          q_nxt     = q_step;
          step_fire = 1'b1;
          cnt_nxt   = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state  <= IDLE;
      cnt    <= '0;
      q      <= SEED;
      done_q <= 1'b0;
      zfix_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      done_q <= done_nxt;
      zfix_q <= zfix_nxt;
    end
  end

  assign data_out = q;
  assign cmd.done = done_q;
  assign zero_fix = zfix_q;

`ifdef LFSR_PERIOD_CHK_EN
  logic [WIDTH-1:0] ref_word;
  logic [WIDTH-1:0] pcnt;
  logic             pwrap;

  // Reference is re-captured on every load so the period is measured from the new start word.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ref_word <= SEED;
      pcnt     <= '0;
      pwrap    <= 1'b0;
    end else if (load) begin
      ref_word <= load_val;
      pcnt     <= '0;
      pwrap    <= 1'b0;
    end else if (step_fire) begin
      if (q_step == ref_word) begin
        pcnt  <= '0;
        pwrap <= 1'b1;
      end else begin
        pcnt  <= pcnt + WIDTH'(1);
        pwrap <= 1'b0;
      end
    end else begin
      pwrap <= 1'b0;
    end
  end

  assign period_wrap = pwrap;
  assign period_cnt  = pcnt;
`endif

endmodule

// File: tb/tb_lfsr_param.sv
// Directed self-checking bench for lfsr_param (default WIDTH=8, TAPS=0x1C, SEED=0x01).
module tb_lfsr_param;

  logic       clk;
  logic       res_n;
  logic       load;
  logic [7:0] data_in;
  logic       en;
  logic       zero_fix;
  logic [7:0] data_out;
`ifdef LFSR_PERIOD_CHK_EN
  logic       period_wrap;
  logic [7:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  lfsr_param_if #(.CNT_W(8)) cmd_if ();

  lfsr_param dut (
    .clk        (clk),
    .res_n      (res_n),
    .load       (load),
    .data_in    (data_in),
    .en         (en),
    .cmd        (cmd_if.slave),
    .zero_fix   (zero_fix),
`ifdef LFSR_PERIOD_CHK_EN
    .period_wrap(period_wrap),
    .period_cnt (period_cnt),
`endif
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b1; load = 1'b0; data_in = 8'h00; en = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_steps = 8'd0;
    #2 res_n = 1'b0;
    #10;
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL reset_q: got %h want 01", data_out); end
    checks++; if (cmd_if.busy !== 1'b0 || cmd_if.done !== 1'b0 || zero_fix !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b zfix=%b want 0 0 0", cmd_if.busy, cmd_if.done, zero_fix); end
    res_n = 1'b1;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
    tick();
  endtask

  task automatic test_free_run();
    logic [7:0] exp [9];
    exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (data_out !== exp[i]) begin errors++; $display("FAIL free_run[%0d]: got %h want %h", i, data_out, exp[i]); end
      tick();
    end
    en = 1'b0;
    checks++; if (data_out !== 8'h3A) begin errors++; $display("FAIL free_run_end: got %h want 3a", data_out); end
  endtask

  task automatic test_burst();
    logic [7:0] exp [3];
    exp = '{8'h57, 8'hAE, 8'h41};
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL burst_load: got %h want a5", data_out); end
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 8'd3;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_pre: got %b want 1", cmd_if.cmd_ready); end
    tick();
    cmd_if.cmd_valid = 1'b0;
    checks++; if (data_out !== 8'hA5 || cmd_if.busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL burst_accept: q=%h busy=%b rdy=%b want a5 1 0", data_out, cmd_if.busy, cmd_if.cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (data_out !== exp[i]) begin errors++; $display("FAIL burst_step[%0d]: got %h want %h", i, data_out, exp[i]); end
      checks++; if (cmd_if.busy !== (i < 2) || cmd_if.done !== (i == 2)) begin
        errors++; $display("FAIL burst_status[%0d]: busy=%b done=%b want %b %b", i, cmd_if.busy, cmd_if.done, i < 2, i == 2); end
    end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_done: got %b want 1", cmd_if.cmd_ready); end
    tick();
    checks++; if (cmd_if.done !== 1'b0 || data_out !== 8'h41) begin
      errors++; $display("FAIL burst_after: done=%b q=%h want 0 41", cmd_if.done, data_out); end
  endtask

  task automatic test_zero_steps();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 8'd0;
    tick();
    cmd_if.cmd_valid = 1'b0;
    checks++; if (cmd_if.done !== 1'b1 || cmd_if.busy !== 1'b0 || data_out !== 8'h41) begin
      errors++; $display("FAIL zero_steps: done=%b busy=%b q=%h want 1 0 41", cmd_if.done, cmd_if.busy, data_out); end
    tick();
    checks++; if (cmd_if.done !== 1'b0 || cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL zero_steps_after: done=%b busy=%b want 0 0", cmd_if.done, cmd_if.busy); end
  endtask

  task automatic test_zero_load();
    load = 1'b1; data_in = 8'h00;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL load_ready: got %b want 0", cmd_if.cmd_ready); end
    tick();
    load = 1'b0;
    checks++; if (data_out !== 8'h01 || zero_fix !== 1'b1) begin
      errors++; $display("FAIL zero_load: q=%h zfix=%b want 01 1", data_out, zero_fix); end
    en = 1'b1;
    tick();
    checks++; if (data_out !== 8'h02 || zero_fix !== 1'b0) begin
      errors++; $display("FAIL zero_load_step: q=%h zfix=%b want 02 0", data_out, zero_fix); end
    tick();
    en = 1'b0;
    checks++; if (data_out !== 8'h04) begin errors++; $display("FAIL zero_load_step2: got %h want 04", data_out); end
  endtask

  task automatic test_burst_abort();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 8'd10;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (data_out !== 8'h20 || cmd_if.busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre: q=%h busy=%b want 20 1", data_out, cmd_if.busy); end
    load = 1'b1; data_in = 8'h3C;
    tick();
    load = 1'b0;
    checks++; if (data_out !== 8'h3C || cmd_if.busy !== 1'b0 || cmd_if.done !== 1'b0) begin
      errors++; $display("FAIL abort: q=%h busy=%b done=%b want 3c 0 0", data_out, cmd_if.busy, cmd_if.done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cmd_if.done !== 1'b0 || data_out !== 8'h3C || cmd_if.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL abort_idle[%0d]: done=%b q=%h rdy=%b want 0 3c 1", i, cmd_if.done, data_out, cmd_if.cmd_ready); end
    end
  endtask

  task automatic test_back_to_back();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 8'd2;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    checks++; if (data_out !== 8'h78) begin errors++; $display("FAIL b2b_s1: got %h want 78", data_out); end
    tick();
    checks++; if (data_out !== 8'hF0 || cmd_if.done !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_done1: q=%h done=%b rdy=%b want f0 1 1", data_out, cmd_if.done, cmd_if.cmd_ready); end
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 8'd1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    checks++; if (cmd_if.busy !== 1'b1 || cmd_if.done !== 1'b0 || data_out !== 8'hF0) begin
      errors++; $display("FAIL b2b_accept2: busy=%b done=%b q=%h want 1 0 f0", cmd_if.busy, cmd_if.done, data_out); end
    tick();
    checks++; if (data_out !== 8'hFD || cmd_if.done !== 1'b1 || cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done2: q=%h done=%b busy=%b want fd 1 0", data_out, cmd_if.done, cmd_if.busy); end
    tick();
  endtask

  task automatic test_async_reset();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_steps = 8'd5;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    checks++; if (cmd_if.busy !== 1'b1 || data_out === 8'h01) begin
      errors++; $display("FAIL areset_pre: busy=%b q=%h want 1 not-01", cmd_if.busy, data_out); end
    #2 res_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h01 || cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL areset: q=%h busy=%b want 01 0", data_out, cmd_if.busy); end
    #2 res_n = 1'b1;
    tick();
    checks++; if (data_out !== 8'h01 || cmd_if.busy !== 1'b0 || cmd_if.done !== 1'b0) begin
      errors++; $display("FAIL areset_after: q=%h busy=%b done=%b want 01 0 0", data_out, cmd_if.busy, cmd_if.done); end
  endtask

`ifdef LFSR_PERIOD_CHK_EN
  task automatic test_period();
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL period_start: got %0d want 0", period_cnt); end
    en = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    checks++; if (period_cnt !== 8'd254 || period_wrap !== 1'b0) begin
      errors++; $display("FAIL period_254: cnt=%0d wrap=%b want 254 0", period_cnt, period_wrap); end
    tick();
    en = 1'b0;
    checks++; if (period_wrap !== 1'b1 || period_cnt !== 8'd0 || data_out !== 8'h01) begin
      errors++; $display("FAIL period_wrap: wrap=%b cnt=%0d q=%h want 1 0 01", period_wrap, period_cnt, data_out); end
    tick();
    checks++; if (period_wrap !== 1'b0) begin errors++; $display("FAIL period_pulse: got %b want 0", period_wrap); end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_burst();
    test_zero_steps();
    test_zero_load();
    test_burst_abort();
    test_back_to_back();
    test_async_reset();
`ifdef LFSR_PERIOD_CHK_EN
    test_period();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
Name: lfsr_param

Overview:
- Parametrised Galois LFSR for pseudorandom pattern and BIST stimulus generation.
- Next generation of the team's fixed 8-bit LFSR: configurable width, tap mask and seed.
- Adds free-run enable, synchronous seed load, and a counted-burst command handshake with done pulse.
- Adds zero-lock protection.
- Sits between test/control logic and any datapath that consumes a pseudorandom word per step.

Parameters:
- WIDTH, 8, LFSR register width (3..32).
- TAPS, 8'h1C, Galois tap mask. Bit i (1..WIDTH-1) set: Q[i] <= Q[i-1] ^ Q[WIDTH-1]. Bit 0 is ignored; Q[0] <= Q[WIDTH-1] always. Default gives polynomial x^8+x^4+x^3+x^2+1 (maximal, period 255).
- SEED, 8'h01, reset value and zero-lock replacement value. Must be nonzero.
- CNT_W, 8, width of the burst step count.

Ports:
- clk  input  1  rising-edge clock, drives all flops.
- res_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load of data_in into the LFSR.
- data_in  input  WIDTH  seed value for load.
- en  input  1  free-run step enable, honoured only in IDLE.
- cmd_valid  input  1  burst request.
- cmd_steps  input  CNT_W  number of steps in the burst; 0 is legal.
- cmd_ready  output  1  high in IDLE with load low.
- busy  output  1  high while in BURST.
- done  output  1  one-cycle pulse when a burst completes.
- zero_fix  output  1  one-cycle pulse when zero-lock substitution occurs.
- data_out  output  WIDTH  present LFSR state (registered).

Behaviour:
- Reset (res_n low, asynchronous):
  - Q = SEED, FSM = IDLE, step counter = 0.
  - done, zero_fix and busy = 0; cmd_ready = 1 once reset releases.
- Step function: one Galois shift per TAPS as defined above. Every step is visible on data_out the next cycle.
- Priority per cycle: load > burst step > en step > hold.
- load:
  - Q <= data_in next edge, in any state.
  - A load in BURST aborts the burst: FSM -> IDLE, no done pulse.
  - If data_in == 0, Q <= SEED instead and zero_fix pulses next cycle.
- FSM states: IDLE, BURST.
- IDLE:
  - cmd_ready = ~load.
  - Handshake fires when cmd_valid & cmd_ready.
  - If cmd_steps == 0: stay IDLE, done pulses next cycle, Q unchanged.
  - Otherwise: cnt <= cmd_steps, FSM -> BURST. No step occurs on the accept edge.
  - Without a handshake, if en is high, step once per cycle.
- BURST:
  - busy = 1, cmd_ready = 0; en and cmd_valid are ignored.
  - Each cycle: step and decrement cnt.
  - When cnt == 1 on an edge: final step, FSM -> IDLE, done = 1 in the following cycle.
  - A burst of N therefore produces exactly N steps; busy stays high for N cycles after the accept edge.
- Back-to-back commands: cmd_ready returns high in the same cycle done is high. A new command may be accepted that cycle.
- Zero-lock: the step function cannot reach 0 from a nonzero state. Zero can only enter via load, which is covered above.
- Widths: cnt is CNT_W bits and is never wrapped. Maximum burst is 2^CNT_W - 1.

Optional Feature:
- Macro: LFSR_PERIOD_CHK_EN.
- Defined:
  - Adds output period_wrap (1-bit pulse) and output period_cnt (WIDTH bits).
  - Captures a reference word on reset (SEED) and on every load (the loaded value, post-substitution).
  - period_cnt clears on capture and increments on each step.
  - When a step makes Q equal the reference, period_wrap pulses for one cycle and period_cnt clears to 0.
  - Default configuration wraps every 255 steps.
- Undefined: neither port exists and there is no extra logic. Core behaviour is identical.

Test Plan:
- Reset then en=1 for 9 cycles -> data_out 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x1D.
- load=1, data_in=0xA5, then cmd_valid with cmd_steps=3 -> busy high for 3 cycles, data_out advances 3 steps from 0xA5, done single pulse, cmd_ready high with done.
- cmd_steps=0 accepted -> done pulses next cycle, busy never high, data_out unchanged.
- load with data_in=0x00 -> data_out=0x01, zero_fix one pulse; en steps continue normally.
- Burst of 10 with load at step 4 (data_in=0x3C) -> data_out=0x3C, FSM IDLE, no done.
- res_n low mid-burst (asynchronous, between edges) -> data_out=0x01 immediately, busy=0.
- With LFSR_PERIOD_CHK_EN: free-run 255 steps -> period_wrap at step 255, period_cnt back to 0.
